// File: rtl/exe_pkg.sv
// Shared execution-unit types and defaults used by the conversion stage and its result buffer.
package exe_pkg;

    localparam int unsigned EXE_WIDTH = 32;
    localparam int unsigned EXE_DEPTH = 4;
    localparam int unsigned FLAGS_W   = 3;
    localparam int unsigned MAX_W     = 64;
    localparam int unsigned MAX_IDX_W = 6;

    typedef struct packed {
        logic parity;
        logic negative;
        logic zero;
    } res_flags_t;

    // Word arrives zero-extended to MAX_W; zero extension leaves zero and parity unchanged.
    function automatic res_flags_t calc_flags(input logic [MAX_W-1:0] word,
                                              input int unsigned      width);
        res_flags_t f;
        f.zero     = (word == '0);
        f.negative = word[MAX_IDX_W'(width - 1)];
        f.parity   = ^word;
        return f;
    endfunction

endpackage

// File: rtl/exe_resbuf_mem.sv
// Result buffer storage: register array with one write port and one asynchronous read port.
module exe_resbuf_mem #(
    parameter int unsigned DW    = 35,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Contents are deliberately not reset; validity is tracked by the controller.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/exe_result_buf.sv
// Valid/ready result FIFO behind the conversion stage, with occupancy and accepted-word count.
// Optional per-entry status flags are built when EXE_RESBUF_FLAGS_EN is defined.
module exe_result_buf
    import exe_pkg::*;
#(
    parameter int unsigned WIDTH = EXE_WIDTH,
    parameter int unsigned DEPTH = EXE_DEPTH,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    input  logic [WIDTH-1:0]         i_result,
    output logic                     o_ready,
    output logic                     o_valid,
    output logic [WIDTH-1:0]         o_result,
    output logic [2:0]               o_flags,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic [CNT_W-1:0]         o_total
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
`ifdef EXE_RESBUF_FLAGS_EN
    localparam int unsigned ENT_W = WIDTH + FLAGS_W;
`else
    localparam int unsigned ENT_W = WIDTH;
`endif

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic [CNT_W-1:0] total;
    logic [ENT_W-1:0] wr_data;
    logic [ENT_W-1:0] rd_data;
    logic             push;
    logic             pop;

    // Handshake decodes only registered occupancy, so o_ready never depends on i_ready.
    assign o_ready = (level != LVL_W'(DEPTH));
    assign o_valid = (level != '0);
    assign push    = i_valid && o_ready;
    assign pop     = o_valid && i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            total  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push) begin
                level <= level - LVL_W'(1);
            end
            // Saturating count of accepted words.
            if (push && (total != '1)) begin
                total <= total + CNT_W'(1);
            end
        end
    end

    exe_resbuf_mem #(
        .DW    (ENT_W),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (push),
        .i_waddr (wr_ptr),
        .i_wdata (wr_data),
        .i_raddr (rd_ptr),
        .o_rdata (rd_data)
    );

`ifdef EXE_RESBUF_FLAGS_EN
    res_flags_t wr_flags;
    res_flags_t rd_flags;

    // Flags are computed once at push time and stored alongside the word.
    assign wr_flags = calc_flags(MAX_W'(i_result), WIDTH);
    assign wr_data  = {wr_flags, i_result};
    assign rd_flags = res_flags_t'(rd_data[WIDTH +: FLAGS_W]);
    assign o_flags  = o_valid ? rd_flags : '0;
`else
    assign wr_data  = i_result;
    assign o_flags  = '0;
`endif

    assign o_result = o_valid ? rd_data[WIDTH-1:0] : '0;
    assign o_level  = level;
    assign o_total  = total;

endmodule

// File: tb/tb_exe_result_buf.sv
// Scoreboard bench for exe_result_buf: stimulus pushes expectations, a monitor checks each pop.
module tb_exe_result_buf;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 16;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  flags;
    } exp_t;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              i_valid = 1'b0;
    logic [WIDTH-1:0]  i_result = '0;
    logic              o_ready;
    logic              o_valid;
    logic [WIDTH-1:0]  o_result;
    logic [2:0]        o_flags;
    logic              i_ready = 1'b0;
    logic [2:0]        o_level;
    logic [CNT_W-1:0]  o_total;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t mon_e;

    exe_result_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .i_result (i_result),
        .o_ready  (o_ready),
        .o_valid  (o_valid),
        .o_result (o_result),
        .o_flags  (o_flags),
        .i_ready  (i_ready),
        .o_level  (o_level),
        .o_total  (o_total)
    );

    always #5 i_clk = ~i_clk;

    // Expected flags when the flag feature is built, otherwise all zero.
    function automatic logic [2:0] fl(input logic [2:0] f);
`ifdef EXE_RESBUF_FLAGS_EN
        return f;
`else
        return 3'b000 & f;
`endif
    endfunction

    function automatic logic [2:0] exp_flags(input logic [31:0] w);
        return fl({^w, w[31], (w == 32'd0)});
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: whenever a pop will happen on the coming edge, compare head against scoreboard.
    always @(negedge i_clk) begin
        if (i_rst_n && o_valid && i_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got %0h expected none", o_result);
            end else begin
                mon_e = sb.pop_front();
                check("out_data", 64'(o_result), 64'(mon_e.data));
                check("out_flags", 64'(o_flags), 64'(mon_e.flags));
            end
        end
    end

    task automatic push_word(input logic [31:0] w, input logic [2:0] f, input int max_cycles);
        bit acc;
        acc = 1'b0;
        i_valid  = 1'b1;
        i_result = w;
        for (int c = 0; c < max_cycles && !acc; c++) begin
            @(negedge i_clk);
            acc = o_ready;
            @(posedge i_clk);
            #1;
        end
        i_valid = 1'b0;
        if (acc) begin
            sb.push_back({w, f});
        end else begin
            checks++;
            failures++;
            $display("FAIL push_timeout: word %0h got not_accepted expected accepted", w);
        end
    endtask

    task automatic drain(input int max_cycles);
        bit done;
        done = 1'b0;
        i_ready = 1'b1;
        for (int c = 0; c < max_cycles && !done; c++) begin
            @(posedge i_clk);
            #1;
            done = (o_level == 3'd0);
        end
        i_ready = 1'b0;
        check("drain_done", 64'(done), 64'd1);
        check("drain_sb_empty", 64'(sb.size()), 64'd0);
    endtask

    logic [31:0] stream [16];
    time         t0;

    initial begin
        stream = '{32'h00000000, 32'hFFFFFFFF, 32'h12345678, 32'h80000000,
                   32'h00000001, 32'h7FFFFFFF, 32'hDEADBEEF, 32'h0000FFFF,
                   32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00000003, 32'hC0000000,
                   32'h13579BDF, 32'h2468ACE0, 32'h80000001, 32'hFEDCBA98};

        // Reset and idle
        repeat (3) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_level", 64'(o_level), 64'd0);
        check("rst_total", 64'(o_total), 64'd0);
        check("rst_result", 64'(o_result), 64'd0);
        check("rst_flags", 64'(o_flags), 64'd0);

        // Three words with flag corner cases, held then drained
        push_word(32'h00000000, fl(3'b001), 4);
        push_word(32'h80000001, fl(3'b010), 4);
        push_word(32'h00000007, fl(3'b101), 4);
        check("s2_level", 64'(o_level), 64'd3);
        drain(10);
        check("s2_total", 64'(o_total), 64'd3);
        check("empty_result", 64'(o_result), 64'd0);
        check("empty_flags", 64'(o_flags), 64'd0);

        // Fill to full; fifth word held by upstream until a single-cycle pop
        push_word(32'h11111111, exp_flags(32'h11111111), 4);
        push_word(32'h22222222, exp_flags(32'h22222222), 4);
        push_word(32'h33333333, exp_flags(32'h33333333), 4);
        push_word(32'h44444444, exp_flags(32'h44444444), 4);
        check("full_ready", 64'(o_ready), 64'd0);
        check("full_level", 64'(o_level), 64'd4);
        i_valid  = 1'b1;
        i_result = 32'h55555555;
        repeat (2) begin @(posedge i_clk); #1; end
        check("held_level", 64'(o_level), 64'd4);
        check("held_total", 64'(o_total), 64'd7);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1 i_ready = 1'b0;
        check("pulse_level", 64'(o_level), 64'd3);
        check("pulse_ready", 64'(o_ready), 64'd1);
        @(posedge i_clk);
        #1;
        sb.push_back({32'h55555555, exp_flags(32'h55555555)});
        check("refill_level", 64'(o_level), 64'd4);
        check("refill_total", 64'(o_total), 64'd8);

        // Full with valid and ready together: pop only, then push+pop
        i_result = 32'h66666666;
        i_ready  = 1'b1;
        @(posedge i_clk);
        #1;
        check("full_pop_level", 64'(o_level), 64'd3);
        check("full_pop_total", 64'(o_total), 64'd8);
        @(posedge i_clk);
        #1;
        sb.push_back({32'h66666666, exp_flags(32'h66666666)});
        i_valid = 1'b0;
        i_ready = 1'b0;
        check("pushpop_level", 64'(o_level), 64'd3);
        check("pushpop_total", 64'(o_total), 64'd9);
        drain(10);

        // Back-to-back stream with consumer always ready
        i_ready = 1'b1;
        t0 = $time;
        for (int k = 0; k < 16; k++) begin
            push_word(stream[k], exp_flags(stream[k]), 3);
        end
        check("stream_cycles", 64'(($time - t0) / 10), 64'd16);
        check("stream_level", 64'(o_level), 64'd1);
        @(posedge i_clk);
        #1;
        check("stream_level_end", 64'(o_level), 64'd0);
        check("stream_sb_empty", 64'(sb.size()), 64'd0);
        check("stream_total", 64'(o_total), 64'd25);
        i_ready = 1'b0;

        // Asynchronous reset mid-cycle with data buffered
        push_word(32'hCAFEF00D, exp_flags(32'hCAFEF00D), 4);
        push_word(32'h0BADBEEF, exp_flags(32'h0BADBEEF), 4);
        #2 i_rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(o_valid), 64'd0);
        check("arst_ready", 64'(o_ready), 64'd1);
        check("arst_level", 64'(o_level), 64'd0);
        check("arst_total", 64'(o_total), 64'd0);
        check("arst_result", 64'(o_result), 64'd0);
        sb.delete();
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        push_word(32'h00000042, exp_flags(32'h00000042), 4);
        drain(10);
        check("post_rst_total", 64'(o_total), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
